// File: rtl/snn_pkg.sv
// Shared types and helpers for the SNN pixel scheduler: state encoding,
// window length and sign-magnitude weight decode.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    // Wide enough for any (WIDTH+1)-bit sign-magnitude weight in use.
    localparam int SM_MAX_W = 32;
    typedef logic [SM_MAX_W-1:0] sm_weight_t;

    function automatic int win_len(input int width);
        return (1 << (width + 1)) + 2;
    endfunction

    function automatic logic sm_sign(input sm_weight_t w, input int width);
        sm_weight_t s;
        s = w >> width;
        return s[0];
    endfunction

    function automatic sm_weight_t sm_mag(input sm_weight_t w, input int width);
        return w & ((sm_weight_t'(1) << width) - sm_weight_t'(1));
    endfunction

endpackage

// File: rtl/snn_window_counter.sv
// Per-pixel window counter: counts 0..WIN-1 while running, flags the wrap,
// and provides registered first-cycle and settled flags for the window.
module snn_window_counter #(
    parameter int WIN = 514
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_run_nxt,
    output logic o_wrap,
    output logic o_first,
    output logic o_settle
);
    import snn_pkg::*;

    localparam int CW = $clog2(WIN);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_first;
    logic          r_settle;

    assign o_wrap    = (r_cnt == CW'(WIN - 1));
    assign w_cnt_nxt = (i_en && !o_wrap) ? r_cnt + 1'b1 : '0;

    // Flags are computed from the next count so they line up with r_cnt;
    // "first" also stays high whenever the window is not running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_first  <= 1'b1;
            r_settle <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_first  <= !i_run_nxt || (w_cnt_nxt == '0);
            r_settle <= i_run_nxt && (w_cnt_nxt > CW'(2));
        end
    end

    assign o_first  = r_first;
    assign o_settle = r_settle;

endmodule

// File: rtl/snn_pixel_scheduler.sv
// Sequencer for the time-multiplexed SNN perceptron: accepts an image, walks
// each pixel through one full datapath window, then hands back the decision.
// IDLE: wait for image | CLEAR: clear accumulator | RUN: pixel windows | DONE: hold result
module snn_pixel_scheduler #(
    parameter int WIDTH = 8,
    parameter int HEIGHT = 7,
    parameter logic [WIDTH:0] WEIGHTS [HEIGHT] = '{
        (WIDTH+1)'(60), (WIDTH+1)'(60), (WIDTH+1)'(60),
        (WIDTH+1)'(260), (WIDTH+1)'(260), (WIDTH+1)'(260), (WIDTH+1)'(260)},
    localparam int IDX_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              img_valid,
    input  logic [HEIGHT-1:0] img_data,
    output logic              img_ready,
    output logic [IDX_W-1:0]  pixel_idx,
    output logic              pixel_en,
    output logic [WIDTH-1:0]  weight_mag,
    output logic              polarity,
    output logic              dp_rst_n,
    output logic              acc_clear,
    output logic              acc_en,
    input  logic              neuron_in,
    output logic              result_valid,
    output logic              result,
    input  logic              result_ready,
    output logic              busy
);
    import snn_pkg::*;

    localparam int WIN = win_len(WIDTH);

    sched_state_t      r_state;
    sched_state_t      w_state_nxt;
    logic [HEIGHT-1:0] r_img_reg;
    logic [IDX_W-1:0]  r_pixel_idx;
    logic              r_img_ready;
    logic              r_busy;
    logic              r_acc_clear;
    logic              r_result_valid;
    logic              r_result;
    logic              w_wrap;
    logic              w_first;
    logic              w_settle;
    logic              w_last_pixel;
    sm_weight_t        w_weight;

    snn_window_counter #(.WIN(WIN)) u_win (
        .clk       (clk),
        .rst       (rst),
        .i_en      (r_state == RUN),
        .i_run_nxt (w_state_nxt == RUN),
        .o_wrap    (w_wrap),
        .o_first   (w_first),
        .o_settle  (w_settle)
    );

    assign w_last_pixel = (r_pixel_idx == IDX_W'(HEIGHT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (img_valid && r_img_ready) w_state_nxt = CLEAR;
            CLEAR:   w_state_nxt = RUN;
            RUN:     if (w_wrap && w_last_pixel) w_state_nxt = DONE;
            DONE:    if (result_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake and control outputs are registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_img_ready    <= 1'b1;
            r_busy         <= 1'b0;
            r_acc_clear    <= 1'b0;
            r_result_valid <= 1'b0;
            r_result       <= 1'b0;
            r_pixel_idx    <= '0;
            r_img_reg      <= '0;
        end else begin
            r_img_ready    <= (w_state_nxt == IDLE);
            r_busy         <= (w_state_nxt != IDLE);
            r_acc_clear    <= (w_state_nxt == CLEAR);
            r_result_valid <= (w_state_nxt == DONE);
            if (r_state == IDLE && w_state_nxt == CLEAR) begin
                r_img_reg   <= img_data;
                r_pixel_idx <= '0;
            end
            if (r_state == RUN && w_wrap && !w_last_pixel)
                r_pixel_idx <= r_pixel_idx + 1'b1;
            if (r_state == RUN && w_state_nxt == DONE)
                r_result <= neuron_in;
            if (r_state == DONE && w_state_nxt == IDLE)
                r_pixel_idx <= '0;
        end
    end

    assign w_weight     = sm_weight_t'(WEIGHTS[r_pixel_idx]);
    assign weight_mag   = WIDTH'(sm_mag(w_weight, WIDTH));
    assign polarity     = !sm_sign(w_weight, WIDTH);
    assign pixel_en     = (r_state == RUN) && r_img_reg[r_pixel_idx];

    assign img_ready    = r_img_ready;
    assign busy         = r_busy;
    assign pixel_idx    = r_pixel_idx;
    assign acc_clear    = r_acc_clear;
    assign dp_rst_n     = !w_first;
    assign acc_en       = w_settle;
    assign result_valid = r_result_valid;
    assign result       = r_result;

endmodule

// File: tb/tb_snn_pixel_scheduler.sv
// Bench for snn_pixel_scheduler: a small instance (WIDTH=2, HEIGHT=3) checked cycle by
// cycle against a window-arithmetic model, plus a default instance for back-to-back timing.
module tb_snn_pixel_scheduler;

    localparam int SH   = 3;
    localparam int SWIN = 10;
    localparam int DWIN = 514;
    localparam logic [2:0] SWTS [3] = '{3'b011, 3'b111, 3'b001};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       rst_s, img_valid_s, neuron_in_s, result_ready_s;
    logic [2:0] img_data_s;
    logic       img_ready_s, pixel_en_s, polarity_s, dp_rst_n_s, acc_clear_s, acc_en_s;
    logic       result_valid_s, result_s, busy_s;
    logic [1:0] pixel_idx_s, weight_mag_s;

    logic       rst_d, img_valid_d, neuron_in_d, result_ready_d;
    logic [6:0] img_data_d;
    logic       img_ready_d, pixel_en_d, polarity_d, dp_rst_n_d, acc_clear_d, acc_en_d;
    logic       result_valid_d, result_d, busy_d;
    logic [2:0] pixel_idx_d;
    logic [7:0] weight_mag_d;

    snn_pixel_scheduler #(.WIDTH(2), .HEIGHT(3), .WEIGHTS(SWTS)) dut_s (
        .clk(clk), .rst(rst_s), .img_valid(img_valid_s), .img_data(img_data_s),
        .img_ready(img_ready_s), .pixel_idx(pixel_idx_s), .pixel_en(pixel_en_s),
        .weight_mag(weight_mag_s), .polarity(polarity_s), .dp_rst_n(dp_rst_n_s),
        .acc_clear(acc_clear_s), .acc_en(acc_en_s), .neuron_in(neuron_in_s),
        .result_valid(result_valid_s), .result(result_s), .result_ready(result_ready_s),
        .busy(busy_s)
    );

    snn_pixel_scheduler dut_d (
        .clk(clk), .rst(rst_d), .img_valid(img_valid_d), .img_data(img_data_d),
        .img_ready(img_ready_d), .pixel_idx(pixel_idx_d), .pixel_en(pixel_en_d),
        .weight_mag(weight_mag_d), .polarity(polarity_d), .dp_rst_n(dp_rst_n_d),
        .acc_clear(acc_clear_d), .acc_en(acc_en_d), .neuron_in(neuron_in_d),
        .result_valid(result_valid_d), .result(result_d), .result_ready(result_ready_d),
        .busy(busy_d)
    );

    task automatic test_reset();
        logic [9:0] got;
        #12;
        got = {img_ready_s, busy_s, pixel_idx_s, dp_rst_n_s, acc_clear_s, acc_en_s,
               result_valid_s, result_s, pixel_en_s};
        total++;
        if (got !== 10'b1000000000) begin
            bad++;
            $display("FAIL reset_small: got %b want %b", got, 10'b1000000000);
        end
        total++;
        if ({img_ready_d, busy_d, pixel_idx_d, dp_rst_n_d, acc_clear_d, acc_en_d, result_valid_d, result_d}
            !== 10'b1000000000) begin
            bad++;
            $display("FAIL reset_default: got %b want %b",
                     {img_ready_d, busy_d, pixel_idx_d, dp_rst_n_d, acc_clear_d, acc_en_d,
                      result_valid_d, result_d}, 10'b1000000000);
        end
        @(negedge clk);
        rst_s = 1'b1;
        rst_d = 1'b1;
    endtask

    // One image on the small instance. Cycle k is the cycle after the k-th edge past the
    // accept edge: k=0 clear, k=1..SH*SWIN run windows, k=SH*SWIN+1 first result cycle.
    task automatic test_image(input logic [2:0] d, input int hold, input bit rst_in_done);
        logic       cap;
        logic [2:0] w;
        logic [5:0] ec, gc;
        int         p, c;
        bit         run;
        cap = 1'b0;
        @(negedge clk);
        total++;
        if (img_ready_s !== 1'b1) begin
            bad++;
            $display("FAIL idle_ready: got %b want 1", img_ready_s);
        end
        img_valid_s    = 1'b1;
        img_data_s     = d;
        result_ready_s = 1'b0;
        for (int k = 0; k <= SH*SWIN + 1; k++) begin
            @(negedge clk);
            run = (k >= 1) && (k <= SH*SWIN);
            p   = run ? (k - 1) / SWIN : ((k == 0) ? 0 : SH - 1);
            c   = run ? (k - 1) % SWIN : 0;
            ec  = {1'b0, 1'b1, (k == 0), (run && c != 0), (run && c > 2), (k == SH*SWIN + 1)};
            gc  = {img_ready_s, busy_s, acc_clear_s, dp_rst_n_s, acc_en_s, result_valid_s};
            total++;
            if (gc !== ec) begin
                bad++;
                $display("FAIL ctl k=%0d: got %b want %b (ready busy clr dprst accen rv)", k, gc, ec);
            end
            total++;
            if ({pixel_idx_s, pixel_en_s} !== {2'(p), run && d[p]}) begin
                bad++;
                $display("FAIL pixel k=%0d: got idx=%0d en=%b want idx=%0d en=%b",
                         k, pixel_idx_s, pixel_en_s, p, run && d[p]);
            end
            if (run) begin
                w = SWTS[p];
                total++;
                if ({polarity_s, weight_mag_s} !== {!w[2], w[1:0]}) begin
                    bad++;
                    $display("FAIL weight k=%0d: got pol=%b mag=%0d want pol=%b mag=%0d",
                             k, polarity_s, weight_mag_s, !w[2], w[1:0]);
                end
            end
            if (k == SH*SWIN + 1) begin
                total++;
                if (result_s !== cap) begin
                    bad++;
                    $display("FAIL result_capture: got %b want %b", result_s, cap);
                end
            end
            img_data_s     = 3'($urandom);
            neuron_in_s    = (k == SH*SWIN && rst_in_done) ? 1'b1 : 1'($urandom);
            result_ready_s = (k <= SH*SWIN) ? 1'($urandom) : 1'b0;
            if (k == SH*SWIN) cap = neuron_in_s;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            total++;
            if ({result_valid_s, result_s, img_ready_s, busy_s} !== {1'b1, cap, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL done_hold i=%0d: got %b want %b", i,
                         {result_valid_s, result_s, img_ready_s, busy_s}, {1'b1, cap, 1'b0, 1'b1});
            end
            neuron_in_s = ~neuron_in_s;
            img_data_s  = 3'($urandom);
        end
        if (rst_in_done) begin
            #2 rst_s = 1'b0;
            #1;
            total++;
            if ({result_valid_s, result_s, img_ready_s, busy_s, pixel_idx_s} !== 6'b001000) begin
                bad++;
                $display("FAIL reset_in_done: got %b want %b",
                         {result_valid_s, result_s, img_ready_s, busy_s, pixel_idx_s}, 6'b001000);
            end
            @(negedge clk);
            rst_s          = 1'b1;
            img_valid_s    = 1'b0;
            result_ready_s = 1'b0;
        end else begin
            result_ready_s = 1'b1;
            img_valid_s    = 1'b0;
            @(negedge clk);
            total++;
            if ({img_ready_s, busy_s, result_valid_s, pixel_idx_s} !== 5'b10000) begin
                bad++;
                $display("FAIL handshake_idle: got %b want %b",
                         {img_ready_s, busy_s, result_valid_s, pixel_idx_s}, 5'b10000);
            end
            result_ready_s = 1'b0;
        end
    endtask

    task automatic test_reset_mid_run();
        logic [9:0] got;
        @(negedge clk);
        img_valid_s = 1'b1;
        img_data_s  = 3'b111;
        for (int k = 0; k <= 1 + SWIN + 5; k++) begin
            @(negedge clk);
            img_data_s = 3'($urandom);
        end
        total++;
        if ({pixel_idx_s, dp_rst_n_s, acc_en_s} !== 4'b0111) begin
            bad++;
            $display("FAIL pre_reset_pos: got %b want %b", {pixel_idx_s, dp_rst_n_s, acc_en_s}, 4'b0111);
        end
        #2 rst_s = 1'b0;
        #1;
        got = {img_ready_s, busy_s, pixel_idx_s, dp_rst_n_s, acc_clear_s, acc_en_s,
               result_valid_s, result_s, pixel_en_s};
        total++;
        if (got !== 10'b1000000000) begin
            bad++;
            $display("FAIL reset_mid_run: got %b want %b", got, 10'b1000000000);
        end
        @(negedge clk);
        rst_s       = 1'b1;
        img_valid_s = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [6:0] img;
        logic       prev;
        int         n, first, second;
        n      = 0;
        first  = -1;
        second = -1;
        prev   = 1'b0;
        img    = 7'($urandom);
        @(negedge clk);
        result_ready_d = 1'b1;
        img_valid_d    = 1'b1;
        img_data_d     = img;
        neuron_in_d    = 1'b1;
        while (second < 0 && n < 9000) begin
            @(negedge clk);
            n++;
            if (n == 2) begin
                total++;
                if ({pixel_idx_d, polarity_d, weight_mag_d, pixel_en_d} !== {3'd0, 1'b1, 8'd60, img[0]}) begin
                    bad++;
                    $display("FAIL default_pixel0: got %b want %b",
                             {pixel_idx_d, polarity_d, weight_mag_d, pixel_en_d}, {3'd0, 1'b1, 8'd60, img[0]});
                end
            end
            if (n == 2 + 3*DWIN) begin
                total++;
                if ({pixel_idx_d, polarity_d, weight_mag_d, pixel_en_d} !== {3'd3, 1'b0, 8'd4, img[3]}) begin
                    bad++;
                    $display("FAIL default_pixel3: got %b want %b",
                             {pixel_idx_d, polarity_d, weight_mag_d, pixel_en_d}, {3'd3, 1'b0, 8'd4, img[3]});
                end
            end
            if (result_valid_d && !prev) begin
                if (first < 0) begin
                    first = n;
                    total++;
                    if (first != 7*DWIN + 2) begin
                        bad++;
                        $display("FAIL latency_default: got %0d want %0d", first, 7*DWIN + 2);
                    end
                    total++;
                    if (result_d !== 1'b1) begin
                        bad++;
                        $display("FAIL result_default1: got %b want 1", result_d);
                    end
                    neuron_in_d = 1'b0;
                    img_data_d  = 7'($urandom);
                end else begin
                    second = n;
                    total++;
                    if (second - first != 7*DWIN + 3) begin
                        bad++;
                        $display("FAIL throughput: got %0d want %0d", second - first, 7*DWIN + 3);
                    end
                    total++;
                    if (result_d !== 1'b0) begin
                        bad++;
                        $display("FAIL result_default2: got %b want 0", result_d);
                    end
                end
            end
            prev = result_valid_d;
        end
        if (second < 0) begin
            total++;
            bad++;
            $display("FAIL back_to_back_timeout: got first=%0d second=%0d want both seen", first, second);
        end
        img_valid_d = 1'b0;
    endtask

    initial begin
        rst_s = 1'b0; img_valid_s = 1'b0; img_data_s = '0; neuron_in_s = 1'b0; result_ready_s = 1'b0;
        rst_d = 1'b0; img_valid_d = 1'b0; img_data_d = '0; neuron_in_d = 1'b0; result_ready_d = 1'b0;
        test_reset();
        test_image(3'b101, 20, 1'b0);
        test_image(3'($urandom), 3, 1'b0);
        test_reset_mid_run();
        test_image(3'b011, 2, 1'b1);
        test_image(3'($urandom), 1, 1'b0);
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
